// File: rtl/qmult_rr_sched.sv
// Round-robin scheduler sharing one registered sign-magnitude Q-format multiplier among REQS requesters.
// Optional build macro QMULT_SCHED_SAT_EN saturates the product magnitude on overflow.
module qmult_rr_sched #(
    parameter int N    = 32,
    parameter int Q    = 15,
    parameter int REQS = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [REQS-1:0]           i_req_valid,
    input  logic [REQS*N-1:0]         i_req_a,
    input  logic [REQS*N-1:0]         i_req_b,
    output logic [REQS-1:0]           o_req_ready,
    output logic                      o_rsp_valid,
    output logic [$clog2(REQS)-1:0]   o_rsp_id,
    output logic [N-1:0]              o_rsp_result,
    output logic                      o_rsp_ovr,
    input  logic                      i_rsp_ready,
    output logic                      o_busy
);
    localparam int IDW = $clog2(REQS);
    localparam int PW  = 2*N - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r, state_nx_s;
    logic [IDW-1:0]   ptr_r, id_r, grant_s, ptr_nx_s;
    logic             found_s, accept_s;
    logic [N-1:0]     a_r, b_r, res_r;
    logic             ovr_r;
    logic [PW-1:0]    prod_s;

    // Product magnitude overflows when any bit above the kept slice is set.
    function automatic logic prod_ovr(input logic [PW-1:0] p);
        return |p[PW-1:N-1+Q];
    endfunction

    // Sign-magnitude result assembly; low Q bits are truncated.
    function automatic logic [N-1:0] pack_res(input logic sgn, input logic [PW-1:0] p);
        logic [N-2:0] mag;
`ifdef QMULT_SCHED_SAT_EN
        mag = prod_ovr(p) ? {(N-1){1'b1}} : p[N-2+Q:Q];
`else
        mag = p[N-2+Q:Q];
`endif
        return {sgn, mag};
    endfunction

    assign prod_s = {{(N-1){1'b0}}, a_r[N-2:0]} * {{(N-1){1'b0}}, b_r[N-2:0]};

    // Rotating priority search starting at ptr_r.
    always_comb begin
        grant_s = '0;
        found_s = 1'b0;
        for (int i = 0; i < REQS; i++) begin
            int            pos;
            logic [IDW-1:0] idx;
            pos = (int'(ptr_r) + i) % REQS;
            idx = IDW'(pos);
            if (!found_s && i_req_valid[idx]) begin
                found_s = 1'b1;
                grant_s = idx;
            end else begin
                found_s = found_s;
            end
        end
        ptr_nx_s = (grant_s == IDW'(REQS-1)) ? {IDW{1'b0}} : grant_s + IDW'(1);
    end

    // Next-state decode and acceptance strobe.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    accept_s   = 1'b1;
                    state_nx_s = CALC;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CALC: state_nx_s = RESP;
            RESP: begin
                if (i_rsp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand capture on accept, product capture in CALC.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_r <= '0;
            id_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
            ovr_r <= 1'b0;
        end else if (accept_s) begin
            ptr_r <= ptr_nx_s;
            id_r  <= grant_s;
            a_r   <= i_req_a[int'(grant_s)*N +: N];
            b_r   <= i_req_b[int'(grant_s)*N +: N];
        end else if (state_r == CALC) begin
            res_r <= pack_res(a_r[N-1] ^ b_r[N-1], prod_s);
            ovr_r <= prod_ovr(prod_s);
        end
    end

    assign o_req_ready  = (state_r == IDLE && found_s) ?
                          ({{(REQS-1){1'b0}}, 1'b1} << grant_s) : {REQS{1'b0}};
    assign o_rsp_valid  = (state_r == RESP);
    assign o_rsp_id     = id_r;
    assign o_rsp_result = res_r;
    assign o_rsp_ovr    = ovr_r;
    assign o_busy       = (state_r != IDLE);

endmodule

// File: tb/tb_qmult_rr_sched.sv
// Directed bench for qmult_rr_sched: single ops, round-robin order, backpressure, async reset.
module tb_qmult_rr_sched;
    localparam int N    = 32;
    localparam int REQS = 4;

    logic              clk, rst_n;
    logic [REQS-1:0]   req_valid;
    logic [REQS*N-1:0] req_a, req_b;
    logic [REQS-1:0]   req_ready;
    logic              rsp_valid, rsp_ovr, rsp_ready, busy;
    logic [1:0]        rsp_id;
    logic [N-1:0]      rsp_result;
    int                total, bad;

    qmult_rr_sched #(.N(N), .Q(15), .REQS(REQS)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
        .o_req_ready(req_ready),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
        .o_rsp_result(rsp_result), .o_rsp_ovr(rsp_ovr),
        .i_rsp_ready(rsp_ready), .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int k, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[k*N +: N] = a;
        req_b[k*N +: N] = b;
    endtask

    // Called at a negedge in IDLE; runs one isolated operation through to IDLE.
    task automatic run_single(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic [N-1:0] exp_res, input logic exp_ovr);
        logic [REQS-1:0] one;
        one = '0;
        one[k] = 1'b1;
        set_op(k, a, b);
        req_valid = one;
        #1;
        check("single_ready", 64'(req_ready), 64'(one));
        check("single_idle_busy", 64'(busy), 64'd0);
        @(negedge clk);
        req_valid = '0;
        check("single_calc_valid", 64'(rsp_valid), 64'd0);
        check("single_calc_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("single_rsp_valid", 64'(rsp_valid), 64'd1);
        check("single_rsp_id", 64'(rsp_id), 64'(k));
        check("single_rsp_result", 64'(rsp_result), 64'(exp_res));
        check("single_rsp_ovr", 64'(rsp_ovr), 64'(exp_ovr));
        @(negedge clk);
        check("single_back_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [N-1:0] held_res;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        check("rst_result", 64'(rsp_result), 64'd0);
        check("rst_ovr", 64'(rsp_ovr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1.5 * 2.0 = 3.0 on requester 2; ptr moves to 3
        run_single(2, 32'h0000C000, 32'h00010000, 32'h00018000, 1'b0);
        // -1.0 * 2.0 = -2.0 on requester 0; ptr moves to 1
        run_single(0, 32'h80008000, 32'h00010000, 32'h80010000, 1'b0);
        // overflow on requester 3; ptr moves to 0
`ifdef QMULT_SCHED_SAT_EN
        run_single(3, 32'h40000000, 32'h40000000, 32'h7FFFFFFF, 1'b1);
`else
        run_single(3, 32'h40000000, 32'h40000000, 32'h00000000, 1'b1);
`endif

        // All requesters valid: grants 0,1,2,3,0,1, three cycles apart
        for (int k = 0; k < REQS; k++) set_op(k, 32'h00008000, 32'h00008000);
        req_valid = 4'hF;
        #1;
        for (int g = 0; g < 6; g++) begin
            check("rr_grant", 64'(req_ready), 64'(4'b0001 << (g % 4)));
            @(negedge clk);
            check("rr_calc_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
            check("rr_rsp_valid", 64'(rsp_valid), 64'd1);
            check("rr_rsp_id", 64'(rsp_id), 64'(g % 4));
            check("rr_rsp_result", 64'(rsp_result), 64'h00008000);
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        check("rr_drop_ready", 64'(req_ready), 64'd0);
        check("rr_drop_busy", 64'(busy), 64'd0);

        // Backpressure: ptr is 2, only requester 1 valid -> grant 1, ptr moves to 2
        set_op(1, 32'h00010000, 32'h80018000);
        set_op(2, 32'h00000001, 32'h00000001);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        check("bp_grant", 64'(req_ready), 64'b0010);
        @(negedge clk);
        req_valid = 4'b0100;
        @(negedge clk);
        held_res = 32'h80030000;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_id", 64'(rsp_id), 64'd1);
            check("bp_result", 64'(rsp_result), 64'(held_res));
            check("bp_ovr", 64'(rsp_ovr), 64'd0);
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(rsp_valid), 64'd0);
        check("bp_next_grant", 64'(req_ready), 64'b0100);

        // Requester 2 accepted (ptr -> 3); reset during its CALC cycle
        @(negedge clk);
        req_valid = '0;
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 64'(req_ready), 64'd0);
        check("arst_valid", 64'(rsp_valid), 64'd0);
        check("arst_id", 64'(rsp_id), 64'd0);
        check("arst_result", 64'(rsp_result), 64'd0);
        check("arst_ovr", 64'(rsp_ovr), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_op(3, 32'h00008000, 32'h00008000);
        req_valid = 4'b1010;
        #1;
        check("post_rst_grant", 64'(req_ready), 64'b0010);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("post_rst_valid", 64'(rsp_valid), 64'd1);
        check("post_rst_id", 64'(rsp_id), 64'd1);
        check("post_rst_result", 64'(rsp_result), 64'h80030000);
        @(negedge clk);
        check("post_rst_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
